// File: rtl/fifo_lane_unpacker.sv
// Unpacks wide FIFO words into narrow lanes on a valid/ready stream, one lane per clock.
// Define FIFO_UNPACK_MSB_FIRST_EN to emit the most-significant lane of each word first.
module fifo_lane_unpacker #(
    parameter int p1width      = 32,
    parameter int p2lanes      = 4,
    parameter int p3cntr_width = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       CLR,
    input  logic [p1width-1:0]         FIFO_D,
    input  logic                       FIFO_EMPTY_N,
    output logic                       FIFO_DEQ,
    output logic [p1width/p2lanes-1:0] OUT_DATA,
    output logic                       OUT_VALID,
    output logic                       OUT_FIRST,
    output logic                       OUT_LAST,
    input  logic                       OUT_READY
);

    localparam int LW = p1width / p2lanes;
    localparam logic [p3cntr_width-1:0] LAST_LANE = p3cntr_width'(p2lanes - 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                  state;
    logic [p1width-1:0]      hold;
    logic [p3cntr_width-1:0] lane;
    logic [LW-1:0]           lanes [p2lanes];
    logic                    hold_valid;
    logic                    take;
    logic                    final_take;

    assign hold_valid = (state == HOLD);
    assign take       = hold_valid & OUT_READY;
    assign final_take = take & (lane == LAST_LANE);

    // Held in reset the FIFO must not see a dequeue, even while its head is valid.
    assign FIFO_DEQ = RST_N & ~CLR & FIFO_EMPTY_N & (~hold_valid | final_take);

    for (genvar k = 0; k < p2lanes; k++) begin : g_lane
`ifdef FIFO_UNPACK_MSB_FIRST_EN
        assign lanes[k] = hold[(p2lanes-1-k)*LW +: LW];
`else
        assign lanes[k] = hold[k*LW +: LW];
`endif
    end

    assign OUT_DATA  = lanes[lane];
    assign OUT_VALID = hold_valid;
    assign OUT_FIRST = hold_valid & (lane == '0);
    assign OUT_LAST  = hold_valid & (lane == LAST_LANE);

    // Dequeue wins over the final take so the next word follows without a bubble.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= EMPTY;
            hold  <= '0;
            lane  <= '0;
        end else if (CLR) begin
            state <= EMPTY;
            lane  <= '0;
        end else if (FIFO_DEQ) begin
            state <= HOLD;
            hold  <= FIFO_D;
            lane  <= '0;
        end else if (final_take) begin
            state <= EMPTY;
            lane  <= '0;
        end else if (take) begin
            lane <= lane + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_deq_nonempty: assert property (@(posedge CLK) disable iff (!RST_N) FIFO_DEQ |-> FIFO_EMPTY_N)
        else $warning("fifo_lane_unpacker: dequeue while FIFO empty");
    a_width_divides: assert property (@(posedge CLK) (p1width % p2lanes) == 0)
        else $fatal(1, "fifo_lane_unpacker: p1width not divisible by p2lanes");
    a_cntr_width: assert property (@(posedge CLK) p3cntr_width >= 1 && (1 << p3cntr_width) >= p2lanes)
        else $fatal(1, "fifo_lane_unpacker: p3cntr_width too small");
`endif

endmodule

// File: tb/tb_fifo_lane_unpacker.sv
// Scoreboard bench for fifo_lane_unpacker: a FIFO model feeds words, expected lanes are queued on push.
// Honors FIFO_UNPACK_MSB_FIRST_EN for the expected lane order.
module tb_fifo_lane_unpacker;

    localparam int W     = 32;
    localparam int LANES = 4;
    localparam int CW    = 2;
    localparam int LW    = W / LANES;

    typedef struct packed {
        logic [LW-1:0] data;
        logic          first;
        logic          last;
    } exp_t;

    logic          CLK;
    logic          RST_N;
    logic          CLR;
    logic [W-1:0]  FIFO_D;
    logic          FIFO_EMPTY_N;
    logic          FIFO_DEQ;
    logic [LW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_FIRST;
    logic          OUT_LAST;
    logic          OUT_READY;

    logic [W-1:0] fifo_q [$];
    exp_t         exp_q  [$];
    int           n_cmp;
    int           n_bad;

    fifo_lane_unpacker #(.p1width(W), .p2lanes(LANES), .p3cntr_width(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .FIFO_D(FIFO_D), .FIFO_EMPTY_N(FIFO_EMPTY_N), .FIFO_DEQ(FIFO_DEQ),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_FIRST(OUT_FIRST),
        .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic refresh();
        FIFO_EMPTY_N = (fifo_q.size() > 0);
        FIFO_D       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        int   idx;
        fifo_q.push_back(w);
        for (int k = 0; k < LANES; k++) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
            idx = LANES - 1 - k;
`else
            idx = k;
`endif
            e.data  = w[idx*LW +: LW];
            e.first = (k == 0);
            e.last  = (k == LANES - 1);
            exp_q.push_back(e);
        end
        refresh();
    endtask

    // One clock: drive, sample before the edge, then let the FIFO model react to the dequeue.
    task automatic cycle(input logic rdy, input logic clr, output logic deq, output logic vld,
                         output logic took, output exp_t obs);
        OUT_READY = rdy;
        CLR       = clr;
        #1;
        deq  = FIFO_DEQ;
        vld  = OUT_VALID;
        took = OUT_VALID & rdy;
        obs  = {OUT_DATA, OUT_FIRST, OUT_LAST};
        @(posedge CLK);
        if (deq && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (clr) fifo_q.delete();
        #1;
        refresh();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CLR = 1'b0; OUT_READY = 1'b0;
        fifo_q.delete(); exp_q.delete();
        refresh();
        #3;
        n_cmp++;
        if ({OUT_VALID, OUT_FIRST, OUT_LAST, FIFO_DEQ} !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL reset_flags got=%b want=0000", {OUT_VALID, OUT_FIRST, OUT_LAST, FIFO_DEQ});
        end
        n_cmp++;
        if (OUT_DATA !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_data got=%h want=0", OUT_DATA);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_idle_valid got=%b want=0", OUT_VALID);
        end
    endtask

    task automatic test_single_word();
        logic deq, vld, took;
        exp_t obs, e;
        int   deqs = 0;
        push_word(32'hDDCCBBAA);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, deq, vld, took, obs);
            deqs += int'(deq);
            n_cmp++;
            if (vld !== (i >= 1 && i <= 4)) begin
                n_bad++;
                $display("[TB] FAIL single_valid cyc=%0d got=%b want=%b", i, vld, (i >= 1 && i <= 4));
            end
            if (took) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL single_lane cyc=%0d got=%h want=%h", i, obs, e);
                end
            end
            if (i == 0) begin
                n_cmp++;
                if (deq !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL single_deq_latency got=%b want=1", deq);
                end
            end
        end
        n_cmp++;
        if (deqs != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL single_totals deqs=%0d left=%0d want 1/0", deqs, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic deq, vld, took;
        exp_t obs, e;
        push_word(32'h44332211);
        push_word(32'h88776655);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, deq, vld, took, obs);
            n_cmp++;
            if (deq !== (i == 0 || i == 4) || vld !== (i >= 1 && i <= 8)) begin
                n_bad++;
                $display("[TB] FAIL b2b_ctrl cyc=%0d got deq=%b vld=%b want deq=%b vld=%b",
                         i, deq, vld, (i == 0 || i == 4), (i >= 1 && i <= 8));
            end
            if (took) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_lane cyc=%0d got=%h want=%h", i, obs, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic deq, vld, took;
        exp_t obs, e;
        logic rdy_pat [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        push_word(32'hDDCCBBAA);
        push_word(32'h44332211);
        for (int i = 0; i < 11; i++) begin
            cycle(rdy_pat[i], 1'b0, deq, vld, took, obs);
            n_cmp++;
            if (deq !== (i == 0 || i == 6)) begin
                n_bad++;
                $display("[TB] FAIL bp_deq cyc=%0d got=%b want=%b", i, deq, (i == 0 || i == 6));
            end
            if (vld && !took) begin
                n_cmp++;
                if (obs !== exp_q[0]) begin
                    n_bad++;
                    $display("[TB] FAIL bp_stable cyc=%0d got=%h want=%h", i, obs, exp_q[0]);
                end
            end
            if (took) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL bp_lane cyc=%0d got=%h want=%h", i, obs, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL bp_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_clear();
        logic deq, vld, took;
        exp_t obs, e;
        push_word(32'h44332211);
        push_word(32'h88776655);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, (i == 3), deq, vld, took, obs);
            if (took) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL clr_lane cyc=%0d got=%h want=%h", i, obs, e);
                end
            end
            if (i == 3) begin
                exp_q.delete();
                n_cmp++;
                if (deq !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL clr_deq got=%b want=0", deq);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (vld !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL clr_valid got=%b want=0", vld);
                end
            end
        end
        push_word(32'hDDCCBBAA);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, deq, vld, took, obs);
            if (took) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL clr_restart cyc=%0d got=%h want=%h", i, obs, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL clr_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic deq, vld, took;
        exp_t obs, e;
        push_word(32'h44332211);
        cycle(1'b1, 1'b0, deq, vld, took, obs);
        cycle(1'b1, 1'b0, deq, vld, took, obs);
        if (took) void'(exp_q.pop_front());
        push_word(32'h88776655);
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({OUT_VALID, FIFO_DEQ, OUT_LAST, OUT_FIRST} !== 4'b0000 || OUT_DATA !== '0) begin
            n_bad++;
            $display("[TB] FAIL areset_drop got vld=%b deq=%b last=%b first=%b data=%h want all 0",
                     OUT_VALID, FIFO_DEQ, OUT_LAST, OUT_FIRST, OUT_DATA);
        end
        fifo_q.delete(); exp_q.delete();
        refresh();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, deq, vld, took, obs);
            n_cmp++;
            if (vld !== 1'b0 || deq !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL areset_idle cyc=%0d got vld=%b deq=%b want 0/0", i, vld, deq);
            end
        end
        push_word(32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, deq, vld, took, obs);
            if (took) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL areset_after cyc=%0d got=%h want=%h", i, obs, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL areset_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
